// File: rtl/fpga_cfg_pkg.sv
// Shared FPGA configuration: datapath width, default Sobol dimension count and
// the index-sequencer state encoding.
package fpga_cfg_pkg;

    localparam int FP_WIDTH = 32;
    localparam int SOBOL_M  = 50;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } sobol_seq_state_t;

    // A single-dimension run still needs a 1-bit dimension field.
    function automatic int dim_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sobol_idx_seq_if.sv
// Beat stream from the path/dimension index sequencer to the Sobol stage.
interface sobol_idx_seq_if
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int DIM_W = dim_width(SOBOL_M)
);
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] idx_out;
    logic [DIM_W-1:0] dim_out;

    modport master (output valid_out, idx_out, dim_out, input ready_in);
    modport slave  (input valid_out, idx_out, dim_out, output ready_in);
endinterface

// File: rtl/sobol_idx_seq.sv
// Path-major (idx, dim) sequencer for one Sobol lane.
// Optional build macro SOBOL_SEQ_SKIP_ZERO_EN: start at LANE_ID+1 and emit idx <= n_paths.
module sobol_idx_seq
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH     = FP_WIDTH,
    parameter int M         = SOBOL_M,
    parameter int LANE_ID   = 0,
    parameter int NUM_LANES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] n_paths,
    sobol_idx_seq_if.master  seq,
    output logic             busy,
    output logic             done
);

    localparam int DIM_W = dim_width(M);
`ifdef SOBOL_SEQ_SKIP_ZERO_EN
    localparam int FIRST_OFS = 1;
`else
    localparam int FIRST_OFS = 0;
`endif
    // One extra bit keeps idx + NUM_LANES from wrapping back under n_paths.
    localparam logic [WIDTH:0]   FIRST_IDX = (WIDTH+1)'(LANE_ID + FIRST_OFS);
    localparam logic [WIDTH:0]   STRIDE    = (WIDTH+1)'(NUM_LANES);
    localparam logic [DIM_W-1:0] LAST_DIM  = DIM_W'(M - 1);

    function automatic logic idx_ok(input logic [WIDTH:0] idx, input logic [WIDTH:0] n);
`ifdef SOBOL_SEQ_SKIP_ZERO_EN
        return idx <= n;
`else
        return idx < n;
`endif
    endfunction

    sobol_seq_state_t state_reg, state_next;
    logic [WIDTH:0]   idx_reg, idx_next;
    logic [WIDTH:0]   n_reg, n_next;
    logic [DIM_W-1:0] dim_reg, dim_next;
    logic [WIDTH:0]   idx_step;
    logic [WIDTH:0]   n_in;
    logic             final_beat;

    always_comb begin
        idx_step   = idx_reg + STRIDE;
        n_in       = {1'b0, n_paths};
        final_beat = (dim_reg == LAST_DIM) && !idx_ok(idx_step, n_reg);
        state_next = state_reg;
        idx_next   = idx_reg;
        dim_next   = dim_reg;
        n_next     = n_reg;
        unique case (state_reg)
            SEQ_IDLE: begin
                if (start) begin
                    n_next     = n_in;
                    idx_next   = FIRST_IDX;
                    dim_next   = '0;
                    state_next = idx_ok(FIRST_IDX, n_in) ? SEQ_RUN : SEQ_DONE;
                end
            end
            SEQ_RUN: begin
                // Abort wins even over the final beat, so no done follows.
                if (abort) begin
                    state_next = SEQ_IDLE;
                end else if (seq.ready_in) begin
                    if (final_beat) begin
                        state_next = SEQ_DONE;
                    end else if (dim_reg == LAST_DIM) begin
                        dim_next = '0;
                        idx_next = idx_step;
                    end else begin
                        dim_next = dim_reg + DIM_W'(1);
                    end
                end
            end
            SEQ_DONE: state_next = SEQ_IDLE;
            default:  state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SEQ_IDLE;
            idx_reg   <= '0;
            dim_reg   <= '0;
            n_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            dim_reg   <= dim_next;
            n_reg     <= n_next;
        end
    end

    assign seq.valid_out = (state_reg == SEQ_RUN);
    assign seq.idx_out   = idx_reg[WIDTH-1:0];
    assign seq.dim_out   = dim_reg;
    assign busy          = (state_reg == SEQ_RUN);
    assign done          = (state_reg == SEQ_DONE);

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        seq.valid_out && !seq.ready_in && !abort |=>
        seq.valid_out && $stable(seq.idx_out) && $stable(seq.dim_out));

    a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(done && busy));

    a_dim_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(dim_reg) < M);

endmodule
